acc_mem_loader: RTL and testbench
=================================

ACC_MEM_LOADER -- requirements
Module: acc_mem_loader

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of parallel image RAM banks (1..4).
REQ-002 SHALL have parameter DATA_W, default 8, RAM element width; NUM_BANKS*DATA_W <= 32 and 32 % DATA_W == 0.
REQ-003 SHALL have parameter IMG_AW, default 10, image bank address width.
REQ-004 SHALL have parameter WGT_AW, default 15, weight RAM address width.
REQ-005 SHALL have ports:
 clk  in  1  clock
 reset  in  1  reset, asynchronous, active-high
 chipselect  in  1  bus slave select
 write  in  1  bus write strobe
 read  in  1  bus read strobe
 address  in  3  register index
 writedata  in  32  bus write data
 readdata  out  32  bus read data
 img_wren  out  NUM_BANKS  per-bank image write enables
 img_addr  out  IMG_AW  shared image write address
 img_data  out  NUM_BANKS*DATA_W  bank k data at slice k
 wgt_wren  out  1  weight RAM write enable
 wgt_addr  out  WGT_AW  weight write address
 wgt_data  out  DATA_W  weight write data
 busy  out  1  transfer in progress
 done  out  1  sticky transfer-complete flag

Function
REQ-006 SHALL decode bus writes (chipselect&&write) at: 0 CTRL (bits[1:0] mode 1=image 2=weight, bit 2 start), 1 LENGTH (element count, low 16 bits), 2 DATA, 3 BASE (start address, low 16 bits).
REQ-007 SHALL return on bus read, one cycle later: addr 3'h4 STATUS {29'b0, overflow, done, busy}, addr 3'h5 element count written so far, others 0.
REQ-008 SHALL implement FSM states IDLE, IMG, WGT, UNPACK; reset state IDLE.
REQ-009 SHALL on CTRL write with start=1 and mode 1 or 2: load address counter from BASE, clear count/done/overflow, enter IMG or WGT; mode 0 or 3 with start forces IDLE.
REQ-010 SHALL in IMG, per DATA write, assert all img_wren bits for exactly one cycle (next cycle) with bank k data = writedata[k*DATA_W +: DATA_W], then increment img_addr and count by 1.
REQ-011 SHALL in WGT, per DATA write, latch writedata and go UNPACK, emitting 32/DATA_W consecutive single-cycle wgt_wren pulses, lowest slice first, wgt_addr incrementing each pulse, count +1 per pulse.
REQ-012 SHALL in UNPACK stop emitting once count reaches LENGTH even mid-word, then set done and go IDLE.
REQ-013 SHALL on IMG count reaching LENGTH set done and go IDLE the cycle after the final write.
REQ-014 SHALL drive busy=1 in IMG, WGT, UNPACK, else 0.
REQ-015 SHALL drop a DATA write arriving in UNPACK or IDLE, and set sticky overflow.
REQ-016 SHALL wrap address counters modulo 2^IMG_AW / 2^WGT_AW without flagging.
REQ-017 SHALL treat LENGTH=0 with start as immediate completion: done=1 next cycle, no RAM writes.
REQ-018 SHALL give CTRL-start precedence over an in-flight transfer: abort, discard remaining UNPACK slices, restart.
REQ-019 SHALL ignore LENGTH/BASE writes while busy (no effect on active transfer).

Reset
REQ-020 SHALL on reset clear all registers: readdata, img_wren, img_addr, img_data, wgt_wren, wgt_addr, wgt_data, busy, done, overflow, count, LENGTH, BASE = 0; FSM IDLE.
REQ-021 SHALL on reset mid-UNPACK emit no further wren pulses after reset asserts.

Structure
REQ-022 SHALL place register offsets, mode encodings and the FSM state enum in shared package acc_pkg.
REQ-023 SHALL implement the weight slice serialiser as sub-module acc_unpacker (load, shift, slice-valid).

Verification
REQ-024 Image: BASE=0x10, LENGTH=2, start mode 1, DATA 0x44332211, 0x88776655 -> img_wren=4'hF twice, addr 0x10 bank0=0x11..bank3=0x44, addr 0x11 bank0=0x55; done=1, busy=0.
REQ-025 Weight: BASE=0, LENGTH=6, mode 2, DATA 0xDDCCBBAA, 0x0000FFEE -> wgt pulses AA,BB,CC,DD at 0..3, EE,FF at 4..5 only; done=1; count=6.
REQ-026 Overflow: DATA written in cycle after DATA during UNPACK -> dropped, STATUS bit2=1, no extra pulses.
REQ-027 Wrap: IMG_AW=10, BASE=0x3FF, LENGTH=2 -> writes at 0x3FF then 0x000.
REQ-028 Abort/reset: start mode 2 LENGTH=8, after 2 pulses issue start mode 1 -> no further wgt pulses, img mode active; repeat with async reset -> all outputs 0 immediately.
REQ-029 LENGTH=0 start -> done=1 next cycle, zero wren pulses.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared register map, mode encodings, FSM states and bus request type
// for the accelerator memory loader.
package acc_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LENGTH = 3'd1;
  localparam logic [2:0] REG_DATA   = 3'd2;
  localparam logic [2:0] REG_BASE   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_COUNT  = 3'd5;

  localparam logic [1:0] MODE_IMG = 2'd1;
  localparam logic [1:0] MODE_WGT = 2'd2;

  localparam int CTRL_START_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IMG,
    ST_WGT,
    ST_UNPACK
  } state_e;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/acc_unpacker.sv
// Weight word serialiser: holds one 32-bit word and presents it one
// DATA_W slice at a time, lowest slice first.
module acc_unpacker
  import acc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [31:0]       load_word,
  input  logic              shift,
  input  logic              flush,
  output logic [DATA_W-1:0] slice,
  output logic              slice_vld,
  output logic              last
);

  localparam int SLICES = 32 / DATA_W;
  localparam int RW     = $clog2(SLICES + 1);

  logic [31:0]   word_q, word_d;
  logic [RW-1:0] rem_q, rem_d;

  // Flush wins so an abort can never leak a stale slice.
  always_comb begin
    word_d = word_q;
    rem_d  = rem_q;
    if (flush) begin
      word_d = '0;
      rem_d  = '0;
    end else if (load) begin
      word_d = load_word;
      rem_d  = RW'(SLICES);
    end else if (shift && rem_q != '0) begin
      word_d = word_q >> DATA_W;
      rem_d  = rem_q - RW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      rem_q  <= '0;
    end else begin
      word_q <= word_d;
      rem_q  <= rem_d;
    end
  end

  assign slice     = word_q[DATA_W-1:0];
  assign slice_vld = (rem_q != '0);
  assign last      = (rem_q == RW'(1));

endmodule

// File: rtl/acc_mem_loader.sv
// Bus-slave loader that streams host words into banked image RAM or,
// slice by slice, into the weight RAM.
module acc_mem_loader
  import acc_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 8,
  parameter int IMG_AW    = 10,
  parameter int WGT_AW    = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic                        read,
  input  logic [2:0]                  address,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic [NUM_BANKS-1:0]        img_wren,
  output logic [IMG_AW-1:0]           img_addr,
  output logic [NUM_BANKS*DATA_W-1:0] img_data,
  output logic                        wgt_wren,
  output logic [WGT_AW-1:0]           wgt_addr,
  output logic [DATA_W-1:0]           wgt_data,
  output logic                        busy,
  output logic                        done
);

  localparam int IMG_W = NUM_BANKS * DATA_W;

  bus_req_t req;
  assign req = '{wr: chipselect & write, rd: chipselect & read,
                 addr: address, wdata: writedata};

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d, base_q, base_d, cnt_q, cnt_d, cnt_inc;
  logic                done_q, done_d, ovf_q, ovf_d;
  logic [IMG_AW-1:0]   img_ptr_q, img_ptr_d;
  logic [WGT_AW-1:0]   wgt_ptr_q, wgt_ptr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NUM_BANKS-1:0] img_wren_q, img_wren_d;
  logic [IMG_AW-1:0]   img_addr_q, img_addr_d;
  logic [IMG_W-1:0]    img_data_q, img_data_d;
  logic                wgt_wren_q, wgt_wren_d;
  logic [WGT_AW-1:0]   wgt_addr_q, wgt_addr_d;
  logic [DATA_W-1:0]   wgt_data_q, wgt_data_d;

  logic                up_load, up_shift, up_flush, up_vld, up_last;
  logic [DATA_W-1:0]   up_slice;
  logic                busy_w;

  assign busy_w  = (state_q != ST_IDLE);
  assign cnt_inc = cnt_q + 16'd1;

  acc_unpacker #(.DATA_W(DATA_W)) u_unpacker (
    .clk       (clk),
    .reset     (reset),
    .load      (up_load),
    .load_word (req.wdata),
    .shift     (up_shift),
    .flush     (up_flush),
    .slice     (up_slice),
    .slice_vld (up_vld),
    .last      (up_last)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    img_ptr_d  = img_ptr_q;
    wgt_ptr_d  = wgt_ptr_q;
    img_wren_d = '0;
    img_addr_d = img_addr_q;
    img_data_d = img_data_q;
    wgt_wren_d = 1'b0;
    wgt_addr_d = wgt_addr_q;
    wgt_data_d = wgt_data_q;
    up_load    = 1'b0;
    up_shift   = 1'b0;
    up_flush   = 1'b0;
    rdata_d    = '0;

    // Slice streaming runs independently of whatever the bus is doing.
    if (state_q == ST_UNPACK) begin
      if (up_vld) begin
        wgt_wren_d = 1'b1;
        wgt_addr_d = wgt_ptr_q;
        wgt_data_d = up_slice;
        wgt_ptr_d  = wgt_ptr_q + WGT_AW'(1);
        cnt_d      = cnt_inc;
        up_shift   = 1'b1;
        if (cnt_inc == len_q) begin
          done_d   = 1'b1;
          state_d  = ST_IDLE;
          up_flush = 1'b1;
        end else if (up_last) begin
          state_d = ST_WGT;
        end
      end else begin
        state_d = ST_WGT;
      end
    end

    if (req.wr) begin
      case (req.addr)
        REG_CTRL: begin
          if (req.wdata[CTRL_START_BIT]) begin
            // Start aborts anything in flight, including this cycle's slice.
            up_flush   = 1'b1;
            up_shift   = 1'b0;
            wgt_wren_d = 1'b0;
            wgt_addr_d = wgt_addr_q;
            wgt_data_d = wgt_data_q;
            wgt_ptr_d  = wgt_ptr_q;
            cnt_d      = cnt_q;
            done_d     = done_q;
            state_d    = ST_IDLE;
            if (req.wdata[1:0] == MODE_IMG || req.wdata[1:0] == MODE_WGT) begin
              img_ptr_d = IMG_AW'(base_q);
              wgt_ptr_d = WGT_AW'(base_q);
              cnt_d     = '0;
              ovf_d     = 1'b0;
              if (len_q == '0) begin
                done_d = 1'b1;
              end else begin
                done_d  = 1'b0;
                state_d = (req.wdata[1:0] == MODE_IMG) ? ST_IMG : ST_WGT;
              end
            end
          end
        end
        REG_LENGTH: if (!busy_w) len_d = req.wdata[15:0];
        REG_BASE:   if (!busy_w) base_d = req.wdata[15:0];
        REG_DATA: begin
          case (state_q)
            ST_IMG: begin
              // Bank k takes its own DATA_W slice of the word.
              img_wren_d = '1;
              img_addr_d = img_ptr_q;
              img_data_d = req.wdata[IMG_W-1:0];
              img_ptr_d  = img_ptr_q + IMG_AW'(1);
              cnt_d      = cnt_inc;
              if (cnt_inc == len_q) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
            ST_WGT: begin
              up_load = 1'b1;
              state_d = ST_UNPACK;
            end
            default: ovf_d = 1'b1;
          endcase
        end
        default: ;
      endcase
    end

    if (req.rd) begin
      case (req.addr)
        REG_STATUS: rdata_d = {29'b0, ovf_q, done_q, busy_w};
        REG_COUNT:  rdata_d = {16'b0, cnt_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      img_ptr_q  <= '0;
      wgt_ptr_q  <= '0;
      rdata_q    <= '0;
      img_wren_q <= '0;
      img_addr_q <= '0;
      img_data_q <= '0;
      wgt_wren_q <= 1'b0;
      wgt_addr_q <= '0;
      wgt_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      img_ptr_q  <= img_ptr_d;
      wgt_ptr_q  <= wgt_ptr_d;
      rdata_q    <= rdata_d;
      img_wren_q <= img_wren_d;
      img_addr_q <= img_addr_d;
      img_data_q <= img_data_d;
      wgt_wren_q <= wgt_wren_d;
      wgt_addr_q <= wgt_addr_d;
      wgt_data_q <= wgt_data_d;
    end
  end

  assign readdata = rdata_q;
  assign img_wren = img_wren_q;
  assign img_addr = img_addr_q;
  assign img_data = img_data_q;
  assign wgt_wren = wgt_wren_q;
  assign wgt_addr = wgt_addr_q;
  assign wgt_data = wgt_data_q;
  assign busy     = busy_w;
  assign done     = done_q;

endmodule

// File: tb/tb_acc_mem_loader.sv
// Directed bench for acc_mem_loader: a transaction-level model predicts
// every RAM write; a negedge monitor matches each DUT write against it.
module tb_acc_mem_loader;
  import acc_pkg::*;

  localparam int NB = 4, DW = 8, IAW = 10, WAW = 15;

  logic            clk = 1'b0;
  logic            reset, chipselect, write, read;
  logic [2:0]      address;
  logic [31:0]     writedata, readdata;
  logic [NB-1:0]   img_wren;
  logic [IAW-1:0]  img_addr;
  logic [NB*DW-1:0] img_data;
  logic            wgt_wren;
  logic [WAW-1:0]  wgt_addr;
  logic [DW-1:0]   wgt_data;
  logic            busy, done;

  always #5 clk = ~clk;

  acc_mem_loader #(.NUM_BANKS(NB), .DATA_W(DW), .IMG_AW(IAW), .WGT_AW(WAW)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .img_wren(img_wren), .img_addr(img_addr), .img_data(img_data),
    .wgt_wren(wgt_wren), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .busy(busy), .done(done)
  );

  int n_vec = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc++;

  // Model state: transfer-level view of the loader.
  int m_mode, m_len, m_base, m_cnt, m_ptr, m_unp_end;
  bit m_done, m_ovf;
  logic [IAW+31:0] q_img[$], act_img[$];
  logic [WAW+DW-1:0] q_wgt[$], act_wgt[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_len = 0; m_base = 0; m_cnt = 0; m_ptr = 0;
    m_unp_end = -1; m_done = 0; m_ovf = 0;
    q_img.delete(); q_wgt.delete();
  endtask

  task automatic model_wr(input logic [2:0] a, input logic [31:0] d);
    int c;
    int n;
    c = cyc;
    case (a)
      REG_CTRL: if (d[2]) begin
        q_img.delete(); q_wgt.delete();
        m_unp_end = -1;
        if (d[1:0] == 2'd1 || d[1:0] == 2'd2) begin
          m_ptr = m_base; m_cnt = 0; m_done = 0; m_ovf = 0;
          if (m_len == 0) begin m_done = 1; m_mode = 0; end
          else m_mode = int'(d[1:0]);
        end else m_mode = 0;
      end
      REG_LENGTH: if (m_mode == 0) m_len = int'(d[15:0]);
      REG_BASE:   if (m_mode == 0) m_base = int'(d[15:0]);
      REG_DATA: begin
        if (m_mode == 1) begin
          q_img.push_back({IAW'(m_ptr), d});
          m_ptr++; m_cnt++;
          if (m_cnt == m_len) begin m_done = 1; m_mode = 0; end
        end else if (m_mode == 2 && c > m_unp_end) begin
          n = m_len - m_cnt;
          if (n > 32 / DW) n = 32 / DW;
          for (int i = 0; i < n; i++) begin
            q_wgt.push_back({WAW'(m_ptr), d[DW*i +: DW]});
            m_ptr++;
          end
          m_cnt += n;
          m_unp_end = c + n;
          if (m_cnt == m_len) begin m_done = 1; m_mode = 0; end
        end else m_ovf = 1;
      end
      default: ;
    endcase
  endtask

  // Every RAM write the DUT makes must be the next one the model predicted.
  always @(negedge clk) if (!reset) begin
    if (img_wren !== '0) begin
      act_img.push_back({img_addr, img_data});
      if (q_img.size() == 0) chk("img_unexpected", {img_wren, img_addr, img_data}, '0);
      else chk("img_write", {img_wren, img_addr, img_data}, {4'hF, q_img.pop_front()});
    end
    if (wgt_wren !== 1'b0) begin
      act_wgt.push_back({wgt_addr, wgt_data});
      if (q_wgt.size() == 0) chk("wgt_unexpected", {wgt_wren, wgt_addr, wgt_data}, '0);
      else chk("wgt_write", {wgt_wren, wgt_addr, wgt_data}, {1'b1, q_wgt.pop_front()});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bwr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1; write = 1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 0; write = 0;
    model_wr(a, d);
  endtask

  task automatic brd(input logic [2:0] a, output logic [31:0] v);
    chipselect = 1; read = 1; address = a;
    @(posedge clk); #1;
    chipselect = 0; read = 0;
    v = readdata;
  endtask

  task automatic chk_status(input string nm, input logic [31:0] lit);
    logic [31:0] v;
    brd(REG_STATUS, v);
    chk({nm, "_model"}, v, {29'b0, m_ovf, m_done, m_mode != 0});
    chk({nm, "_lit"}, v, lit);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk(nm, {readdata, img_wren, img_addr, img_data, wgt_wren, wgt_addr, wgt_data, busy, done}, '0);
  endtask

  logic [31:0] rv;
  logic [7:0] wexp [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

  initial begin
    reset = 1; chipselect = 0; write = 0; read = 0; address = '0; writedata = '0;
    model_reset();
    #12;
    chk_outs_zero("reset_outputs");
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    // Reset status, then DATA while idle is dropped and flagged.
    chk_status("status_after_reset", 32'h0);
    bwr(REG_DATA, 32'h12345678);
    idle(2);
    chk_status("idle_data_ovf", 32'h4);

    // Image transfer.
    act_img.delete();
    bwr(REG_BASE, 32'h10); bwr(REG_LENGTH, 32'd2); bwr(REG_CTRL, 32'h5);
    bwr(REG_DATA, 32'h44332211); bwr(REG_DATA, 32'h88776655);
    chk("img_done_flag", {busy, done}, 2'b01);
    idle(2);
    chk("img_n_writes", act_img.size(), 2);
    chk("img_first", act_img[0], {10'h010, 32'h44332211});
    chk("img_second", act_img[1], {10'h011, 32'h88776655});
    chk("img_bank0_second", act_img[1][7:0], 8'h55);
    chk_status("img_status", 32'h2);
    brd(REG_COUNT, rv); chk("img_count", rv, 32'd2);

    // Weight transfer with a partial final word.
    act_wgt.delete();
    bwr(REG_BASE, 32'h0); bwr(REG_LENGTH, 32'd6); bwr(REG_CTRL, 32'h6);
    bwr(REG_DATA, 32'hDDCCBBAA);
    idle(5);
    bwr(REG_DATA, 32'h0000FFEE);
    idle(6);
    chk("wgt_n_pulses", act_wgt.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("wgt_pulse%0d", i), act_wgt[i], {WAW'(i), wexp[i]});
    chk_status("wgt_status", 32'h2);
    brd(REG_COUNT, rv); chk("wgt_count", rv, 32'd6);

    // DATA during UNPACK is dropped.
    act_wgt.delete();
    bwr(REG_BASE, 32'h20); bwr(REG_LENGTH, 32'd6); bwr(REG_CTRL, 32'h6);
    bwr(REG_DATA, 32'h04030201); bwr(REG_DATA, 32'h08070605);
    idle(5);
    chk_status("ovf_mid", 32'h5);
    bwr(REG_DATA, 32'h00000A09);
    idle(4);
    chk_status("ovf_end", 32'h6);
    chk("ovf_n_pulses", act_wgt.size(), 6);
    chk("ovf_last_pulse", act_wgt[5], {15'h025, 8'h0A});

    // Image address wrap.
    act_img.delete();
    bwr(REG_BASE, 32'h3FF); bwr(REG_LENGTH, 32'd2); bwr(REG_CTRL, 32'h5);
    bwr(REG_DATA, 32'h000000A1); bwr(REG_DATA, 32'h000000B2);
    idle(2);
    chk("wrap_n", act_img.size(), 2);
    chk("wrap_addr0", act_img[0][IAW+31:32], 10'h3FF);
    chk("wrap_addr1", act_img[1][IAW+31:32], 10'h000);

    // LENGTH=0 start completes at once with no writes.
    act_img.delete(); act_wgt.delete();
    bwr(REG_LENGTH, 32'd0); bwr(REG_CTRL, 32'h6);
    chk("len0_done_next", {busy, done}, 2'b01);
    bwr(REG_CTRL, 32'h5);
    chk("len0_img_done_next", {busy, done}, 2'b01);
    idle(4);
    chk("len0_no_writes", act_img.size() + act_wgt.size(), 0);
    chk_status("len0_status", 32'h2);

    // Start during UNPACK aborts after exactly two slices.
    act_wgt.delete(); act_img.delete();
    bwr(REG_LENGTH, 32'd8); bwr(REG_BASE, 32'h0); bwr(REG_CTRL, 32'h6);
    bwr(REG_DATA, 32'h44332211);
    idle(2);
    bwr(REG_CTRL, 32'h5);
    idle(3);
    chk("abort_n_pulses", act_wgt.size(), 2);
    chk("abort_pulse1", act_wgt[1], {15'h001, 8'h22});
    chk_status("abort_img_active", 32'h1);
    bwr(REG_DATA, 32'hCAFEF00D);
    idle(2);
    chk("abort_img_write", act_img.size(), 1);

    // Async reset mid-UNPACK kills everything immediately.
    bwr(REG_CTRL, 32'h6);
    bwr(REG_DATA, 32'h87654321);
    idle(1);
    #3;
    reset = 1;
    model_reset();
    #1;
    chk_outs_zero("async_reset_outputs");
    idle(2);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    idle(6);
    chk_status("post_reset_status", 32'h0);
    brd(REG_COUNT, rv); chk("post_reset_count", rv, 32'd0);
    bwr(REG_CTRL, 32'h6);
    idle(1);
    chk_status("post_reset_len_cleared", 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
